uart_top: RTL and testbench
===========================

Name: uart_top

Overview:
- Full-duplex 8N1 UART: one transmitter, one receiver, one shared baud-tick generator, all in a single `clk` domain.
- Each frame is 1 start bit (0), 8 data bits sent LSB first, and 1 stop bit (1).
- Sits between a parallel byte interface (`dintx`/`newd`, `doutrx`) and the serial pins (`tx`, `rx`).
- One bit period equals one period of the internal baud strobe `uclk`.

Parameters:
- `clk_freq`, default 1000000: input clock frequency in Hz.
- `baud_rate`, default 9600: serial bit rate in bit/s.
- Derived (not a parameter): CLKCOUNT = `clk_freq`/`baud_rate`, integer division; 104 at the defaults.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-low reset.
- `rx` in 1: serial input; idles high.
- `dintx` in 8: byte to transmit.
- `newd` in 1: transmit request, level-sensitive.
- `tx` out 1: serial output; idles high.
- `doutrx` out 8: last received byte.
- `donetx` out 1: high during the stop-bit period of a transmitted frame.
- `donerx` out 1: one-bit-period strobe marking a valid `doutrx`.
- `tx_busy` out 1: transmitter is mid-frame.
- `rx_busy` out 1: receiver is mid-frame.

Behaviour:
- Baud generator:
  - An internal counter on `clk` toggles the internal signal `uclk` every CLKCOUNT/2 cycles (52 at defaults), so one `uclk` period is 104 clk cycles.
  - `uclk` must exist as a named signal in `uart_top`; benches probe `dut.uclk`.
  - The counter and `uclk` power up at 0 through register initialisation. `rst` does NOT affect them; `uclk` keeps running during reset.
- Tick:
  - A tick is the `clk` edge on which `uclk` goes 0→1.
  - All TX and RX state and outputs update only on tick edges or on reset. Observed from outside, they change on `posedge uclk`.
- Reset, when `rst`=0 at a `clk` edge:
  - `tx`=1; `donetx`=0; `donerx`=0; `doutrx`=0; `tx_busy`=0; `rx_busy`=0.
  - Both FSMs go to IDLE.
  - Reset mid-frame aborts the frame immediately, with no done pulse.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: `tx`=1. On a tick with `newd`=1, latch `dintx`, drive `tx`=0 (start bit), set `tx_busy`=1, go to START.
  - START→DATA: on the next tick drive bit0. The following 7 ticks drive bit1..bit7, each held for one tick period.
  - The tick after bit7 drives `tx`=1 (stop bit) and `donetx`=1, then goes to STOP.
  - STOP: on the next tick `donetx`=0 and `tx_busy`=0, return to IDLE. No new start bit is issued on this tick.
  - The frame occupies 10 tick periods.
  - `dintx` changes after the latch do not affect the frame in flight.
  - `newd` is ignored outside IDLE. If `newd` is still high in IDLE, a new frame starts on that tick (back-to-back).
- RX FSM, states IDLE, DATA:
  - IDLE: on a tick with `rx`=0, start is detected; set `rx_busy`=1, clear bit count, go to DATA. There is no mid-bit oversampling; one sample is taken per tick.
  - DATA: on each of the next 8 ticks, sample `rx` and shift it in at the MSB, shifting right, so the first sample ends up in bit0 (LSB first).
  - On the tick that samples bit7:
    - load `doutrx` with the complete byte;
    - assert `donerx`=1;
    - clear `rx_busy`;
    - return to IDLE.
  - `donerx` drops on the next tick.
  - The stop bit is not checked. A low `rx` seen in IDLE on the tick after completion starts a new frame.
  - `doutrx` holds its value until the next completed frame or reset.
- Independence: TX and RX operate independently and simultaneously; there is no internal loopback.

Test Plan:
- Baud: after power-up, measure `uclk`: period = 104 clk cycles; `uclk` toggles while `rst`=0.
- Reset: hold `rst`=0 for 5 `uclk` periods → `tx`=1, `donetx`=`donerx`=0, `doutrx`=0, both busy signals 0.
- TX 0xA5:
  - Stimulus: `newd`=1 with `dintx`=0xA5.
  - Line at successive `uclk` edges: 0, then 1,0,1,0,0,1,0,1, then 1.
  - `donetx` rises with the stop bit; `tx_busy`=1 from the start bit through the stop bit.
  - Repeat for 10 random bytes; each must match bitwise.
- TX hold:
  - Stimulus: drop `newd` right after `donetx` rises, then re-raise it 2 ticks later.
  - Response: exactly one frame per request; no spurious start bit.
- RX 0x3C:
  - Stimulus: `rx`=0 for one tick, then 0,0,1,1,1,1,0,0 on successive ticks.
  - Response: `donerx` pulses on the tick sampling bit7, with `doutrx`=0x3C.
  - Repeat for 10 random bytes.
- Mid-frame reset:
  - Stimulus: assert `rst`=0 during TX bit3 and during RX bit3.
  - Response: `tx`=1; no done pulses; the next request completes correctly.

Source files
------------

// File: rtl/uart_top.sv
// Full-duplex 8N1 UART: a free-running baud strobe generator plus independent
// transmit and receive state machines that advance once per baud tick.
module uart_top #(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [7:0] dintx,
    input  logic       newd,
    output logic       tx,
    output logic [7:0] doutrx,
    output logic       donetx,
    output logic       donerx,
    output logic       tx_busy,
    output logic       rx_busy
);

    localparam int CLKCOUNT = clk_freq / baud_rate;
    localparam int HALF     = (CLKCOUNT / 2 > 1) ? CLKCOUNT / 2 : 1;
    localparam int CW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic {
        RX_IDLE,
        RX_DATA
    } rx_state_e;

    // Baud generator: free-running from power-up, deliberately outside reset
    logic [CW-1:0] bcnt_q = '0;
    logic          uclk_q = 1'b0;
    logic          uclk;
    logic          tick;

    always_ff @(posedge clk) begin
        if (bcnt_q == HALF_M1) begin
            bcnt_q <= '0;
            uclk_q <= ~uclk_q;
        end else begin
            bcnt_q <= bcnt_q + 1'b1;
        end
    end

    assign uclk = uclk_q;
    assign tick = (bcnt_q == HALF_M1) && !uclk_q;

    // Two-flop synchroniser on the asynchronous serial input
    logic [1:0] rx_sync_q = 2'b11;
    logic       rx_s;

    always_ff @(posedge clk) begin
        rx_sync_q <= {rx_sync_q[0], rx};
    end

    assign rx_s = rx_sync_q[1];

    // Transmitter
    tx_state_e  tx_state_q, tx_state_d;
    logic       tx_q, tx_d;
    logic       donetx_q, donetx_d;
    logic       tx_busy_q, tx_busy_d;
    logic [2:0] tx_cnt_q, tx_cnt_d;
    logic [7:0] tx_sh_q, tx_sh_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_d       = tx_q;
        donetx_d   = donetx_q;
        tx_busy_d  = tx_busy_q;
        tx_cnt_d   = tx_cnt_q;
        tx_sh_d    = tx_sh_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (newd) begin
                    tx_sh_d    = dintx;
                    tx_d       = 1'b0;
                    tx_busy_d  = 1'b1;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                tx_d       = tx_sh_q[0];
                tx_sh_d    = {1'b0, tx_sh_q[7:1]};
                tx_cnt_d   = 3'd0;
                tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                if (tx_cnt_q == 3'd7) begin
                    tx_d       = 1'b1;
                    donetx_d   = 1'b1;
                    tx_state_d = TX_STOP;
                end else begin
                    tx_d     = tx_sh_q[0];
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    tx_cnt_d = tx_cnt_q + 3'd1;
                end
            end
            TX_STOP: begin
                tx_d       = 1'b1;
                donetx_d   = 1'b0;
                tx_busy_d  = 1'b0;
                tx_state_d = TX_IDLE;
            end
            default: begin
                tx_d       = 1'b1;
                donetx_d   = 1'b0;
                tx_busy_d  = 1'b0;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_q       <= 1'b1;
            donetx_q   <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= 3'd0;
        end else if (tick) begin
            tx_state_q <= tx_state_d;
            tx_q       <= tx_d;
            donetx_q   <= donetx_d;
            tx_busy_q  <= tx_busy_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tick) begin
            tx_sh_q <= tx_sh_d;
        end
    end

    // Receiver: one sample per tick, stop bit is not checked
    rx_state_e  rx_state_q, rx_state_d;
    logic       donerx_q, donerx_d;
    logic       rx_busy_q, rx_busy_d;
    logic [2:0] rx_cnt_q, rx_cnt_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [7:0] doutrx_q, doutrx_d;

    always_comb begin
        rx_state_d = rx_state_q;
        donerx_d   = 1'b0;
        rx_busy_d  = rx_busy_q;
        rx_cnt_d   = rx_cnt_q;
        rx_sh_d    = rx_sh_q;
        doutrx_d   = doutrx_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_busy_d  = 1'b1;
                    rx_cnt_d   = 3'd0;
                    rx_state_d = RX_DATA;
                end
            end
            RX_DATA: begin
                rx_sh_d = {rx_s, rx_sh_q[7:1]};
                if (rx_cnt_q == 3'd7) begin
                    doutrx_d   = {rx_s, rx_sh_q[7:1]};
                    donerx_d   = 1'b1;
                    rx_busy_d  = 1'b0;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 3'd1;
                end
            end
            default: begin
                rx_busy_d  = 1'b0;
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            donerx_q   <= 1'b0;
            rx_busy_q  <= 1'b0;
            rx_cnt_q   <= 3'd0;
            doutrx_q   <= 8'd0;
        end else if (tick) begin
            rx_state_q <= rx_state_d;
            donerx_q   <= donerx_d;
            rx_busy_q  <= rx_busy_d;
            rx_cnt_q   <= rx_cnt_d;
            doutrx_q   <= doutrx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tick) begin
            rx_sh_q <= rx_sh_d;
        end
    end

    assign tx      = tx_q;
    assign donetx  = donetx_q;
    assign tx_busy = tx_busy_q;
    assign doutrx  = doutrx_q;
    assign donerx  = donerx_q;
    assign rx_busy = rx_busy_q;

endmodule

// File: tb/tb_uart_top.sv
// Directed bench for uart_top at default parameters (104 clk per bit).
module tb_uart_top;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] dintx;
    logic       newd;
    logic       tx;
    logic [7:0] doutrx;
    logic       donetx;
    logic       donerx;
    logic       tx_busy;
    logic       rx_busy;

    int         errs = 0;
    int         checks = 0;
    logic [7:0] rx_prev = 8'h00;

    uart_top #(
        .clk_freq (1000000),
        .baud_rate(9600)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .dintx  (dintx),
        .newd   (newd),
        .tx     (tx),
        .doutrx (doutrx),
        .donetx (donetx),
        .donerx (donerx),
        .tx_busy(tx_busy),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        bit got;
        got = 1'b0;
        fork
            begin
                @(posedge dut.uclk);
                got = 1'b1;
            end
            begin
                #3000;
            end
        join_any
        disable fork;
        if (!got) chk("tick_timeout", 32'(got), 32'd1);
        #1;
    endtask

    // mode 0: drop newd after start, 1: drop after donetx rises, 2: keep high
    task automatic tx_frame(input logic [7:0] b, input int mode);
        dintx = b;
        newd  = 1'b1;
        tick();
        chk($sformatf("tx_%02h_start", b), 32'(tx), 32'd0);
        chk($sformatf("tx_%02h_start_busy", b), 32'(tx_busy), 32'd1);
        chk($sformatf("tx_%02h_start_done", b), 32'(donetx), 32'd0);
        if (mode == 0) newd = 1'b0;
        dintx = ~b;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("tx_%02h_bit%0d", b, i), 32'(tx), 32'(b[i]));
            chk($sformatf("tx_%02h_bit%0d_busy", b, i), 32'(tx_busy), 32'd1);
            chk($sformatf("tx_%02h_bit%0d_done", b, i), 32'(donetx), 32'd0);
        end
        tick();
        chk($sformatf("tx_%02h_stop", b), 32'(tx), 32'd1);
        chk($sformatf("tx_%02h_stop_done", b), 32'(donetx), 32'd1);
        chk($sformatf("tx_%02h_stop_busy", b), 32'(tx_busy), 32'd1);
        if (mode == 1) newd = 1'b0;
        tick();
        chk($sformatf("tx_%02h_end_line", b), 32'(tx), 32'd1);
        chk($sformatf("tx_%02h_end_done", b), 32'(donetx), 32'd0);
        chk($sformatf("tx_%02h_end_busy", b), 32'(tx_busy), 32'd0);
    endtask

    task automatic rx_frame(input logic [7:0] b);
        rx = 1'b0;
        tick();
        chk($sformatf("rx_%02h_start_busy", b), 32'(rx_busy), 32'd1);
        chk($sformatf("rx_%02h_start_done", b), 32'(donerx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick();
            if (i < 7) begin
                chk($sformatf("rx_%02h_bit%0d_busy", b, i), 32'(rx_busy), 32'd1);
                chk($sformatf("rx_%02h_bit%0d_done", b, i), 32'(donerx), 32'd0);
                if (i == 3) chk($sformatf("rx_%02h_hold_prev", b), 32'(doutrx), 32'(rx_prev));
            end else begin
                chk($sformatf("rx_%02h_done", b), 32'(donerx), 32'd1);
                chk($sformatf("rx_%02h_data", b), 32'(doutrx), 32'(b));
                chk($sformatf("rx_%02h_done_busy", b), 32'(rx_busy), 32'd0);
            end
        end
        rx = 1'b1;
        tick();
        chk($sformatf("rx_%02h_done_drop", b), 32'(donerx), 32'd0);
        chk($sformatf("rx_%02h_data_hold", b), 32'(doutrx), 32'(b));
        rx_prev = b;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached before end of test");
        $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] tx_vec [10];
        logic [7:0] rx_vec [10];
        logic [7:0] rb;
        time t0, t1, t2;
        bit  quiet;
        tx_vec = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h55, 8'hAA, 8'h3C, 8'hC3, 8'h7E, 8'hE7};
        rx_vec = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h96, 8'h69, 8'hF0, 8'h0F, 8'h5A, 8'hA5};

        rst   = 1'b0;
        rx    = 1'b1;
        newd  = 1'b0;
        dintx = 8'h00;

        // uclk runs from power-up while reset is held
        @(posedge dut.uclk);
        t0 = $time;
        chk("uclk_first_rise", 32'(t0), 32'd515);
        @(posedge dut.uclk);
        t1 = $time;
        chk("uclk_period", 32'(t1 - t0), 32'd1040);
        repeat (3) @(posedge dut.uclk);
        t2 = $time;
        chk("uclk_5_rises_in_reset", 32'(t2 - t0), 32'd4160);
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_donetx", 32'(donetx), 32'd0);
        chk("rst_donerx", 32'(donerx), 32'd0);
        chk("rst_doutrx", 32'(doutrx), 32'd0);
        chk("rst_tx_busy", 32'(tx_busy), 32'd0);
        chk("rst_rx_busy", 32'(rx_busy), 32'd0);
        rst = 1'b1;

        tx_frame(8'hA5, 0);
        foreach (tx_vec[k]) tx_frame(tx_vec[k], 0);

        // One frame per request, no spurious start while newd is low
        tx_frame(8'hC6, 1);
        tick();
        chk("hold_idle_line", 32'(tx), 32'd1);
        chk("hold_idle_busy", 32'(tx_busy), 32'd0);
        tx_frame(8'h39, 0);

        // newd held high: STOP tick issues no start, next tick starts
        tx_frame(8'h5A, 2);
        tx_frame(8'h96, 0);

        rx_frame(8'h3C);
        foreach (rx_vec[k]) rx_frame(rx_vec[k]);

        // Reset during TX bit3 and RX bit3
        rb    = 8'h00;
        dintx = 8'h81;
        newd  = 1'b1;
        rx    = 1'b0;
        tick();
        newd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx = rb[i];
            tick();
        end
        chk("mid_tx_bit3", 32'(tx), 32'd0);
        chk("mid_rx_busy", 32'(rx_busy), 32'd1);
        #200;
        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_tx_busy", 32'(tx_busy), 32'd0);
        chk("mid_rst_rx_busy", 32'(rx_busy), 32'd0);
        chk("mid_rst_doutrx", 32'(doutrx), 32'd0);
        rst     = 1'b1;
        rx_prev = 8'h00;
        quiet   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (donetx || donerx || !tx || tx_busy || rx_busy) quiet = 1'b0;
        end
        chk("mid_rst_quiet", 32'(quiet), 32'd1);
        tx_frame(8'h4D, 0);
        rx_frame(8'hB2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
